mem_axi_master: RTL
===================

Name: mem_axi_master

Overview:
- Core-side bridge: accepts single-beat read/write requests on the Mem request/response interface and issues them as AXI-lite master transactions.
- Sits between a core or cache and the AXI-lite interconnect. It is the initiator counterpart of the AXI-lite-to-memory slave bridge.
- One outstanding transaction at a time, read or write.

Parameters:
- ADDR_WIDTH, 64, width of the address on both sides.
- DATA_WIDTH, 64, width of the data on both sides; must be a multiple of 8.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- mem_wen  in  1  write request level; held until mem_wvalid.
- mem_waddr  in  ADDR_WIDTH  write address.
- mem_wdata  in  DATA_WIDTH  write data.
- mem_wmask  in  DATA_WIDTH/8  byte strobes.
- mem_wvalid  out  1  one-cycle write-complete pulse.
- mem_ren  in  1  read request level; held until mem_rvalid.
- mem_raddr  in  ADDR_WIDTH  read address.
- mem_rdata  out  DATA_WIDTH  read data; valid with mem_rvalid, then held.
- mem_rvalid  out  1  one-cycle read-complete pulse.
- mem_err  out  1  one-cycle pulse coincident with a completion whose resp != 0.
- m_awaddr  out  ADDR_WIDTH; m_awvalid  out  1; m_awready  in  1
- m_wdata  out  DATA_WIDTH; m_wstrb  out  DATA_WIDTH/8; m_wvalid  out  1; m_wready  in  1
- m_bresp  in  2; m_bvalid  in  1; m_bready  out  1
- m_araddr  out  ADDR_WIDTH; m_arvalid  out  1; m_arready  in  1
- m_rdata  in  DATA_WIDTH; m_rresp  in  2; m_rvalid  in  1; m_rready  out  1

Behaviour:

Reset:
- All outputs 0, including registered addresses and data.
- FSM returns to IDLE and both accept flags clear.
- Reset mid-transaction abandons it silently; no completion pulse is issued.

Single FSM states: IDLE, WREQ, WRESP, RREQ, RRESP, DONE.

IDLE:
- mem_wen=1: latch waddr/wdata/wmask into m_aw*/m_w*; assert m_awvalid=m_wvalid=1; go to WREQ.
- Else mem_ren=1: latch raddr into m_araddr; assert m_arvalid=1; go to RREQ.
- Both requests in the same cycle: the write wins; the read is served after DONE.
- Request-to-AXI-valid latency is 1 cycle.

WREQ:
- AW and W are tracked independently with aw_done and w_done.
- On awvalid&awready, drop m_awvalid and set aw_done. On wvalid&wready, drop m_wvalid and set w_done.
- Both may complete in the same cycle or in either order.
- When both are done (including the same cycle), assert m_bready=1 and go to WRESP.
- Valid, once asserted, stays stable until its handshake; AXI rule.

WRESP:
- On m_bvalid: m_bready<=0; mem_wvalid<=1 for 1 cycle; mem_err<=(m_bresp!=0); go to DONE.

RREQ:
- On m_arready: m_arvalid<=0; m_rready<=1; go to RRESP.

RRESP:
- On m_rvalid: m_rready<=0; mem_rdata<=m_rdata; mem_rvalid<=1 for 1 cycle; mem_err<=(m_rresp!=0); go to DONE.

DONE:
- Completion pulses deassert.
- Stay in DONE until the serviced request (mem_wen or mem_ren) is low, then go to IDLE.
- This prevents a held request level from being reissued.
- A new request seen in the same cycle as the exit is taken in IDLE on the next cycle.

Other rules:
- Request inputs are sampled only in IDLE; changes during a transaction are ignored.
- Handshakes arriving at a master that is not asserting ready/valid are ignored; no spurious completion.
- Interconnect stall has no timeout; the FSM waits indefinitely.

Decomposition:
- Package mem_axi_pkg holds the FSM state enum, the AXI resp encodings (OKAY=0, SLVERR=2, DECERR=3), and a mem request struct {addr, data, mask}.
- No sub-module. A single FSM plus request registers is sufficient.

Test Plan:
1. Write, ready-immediate: mem_wen=1, waddr=0x80, wdata=0xDEADBEEF_CAFEF00D, wmask=0xFF; awready=wready=1 combinationally, bvalid 2 cycles after bready → awvalid and wvalid 1 cycle after wen; mem_wvalid 1-cycle pulse; mem_err=0.
2. Split AW/W: awready 3 cycles after valid, wready after 1 → m_wvalid drops first, m_awvalid holds until its handshake; m_bready asserts only after both complete.
3. Read: mem_ren=1, raddr=0x100; arready after 2 cycles; rvalid with rdata=0x1234_5678_9ABC_DEF0, rresp=0 → mem_rdata equals that value, mem_rvalid single pulse, rdata held afterward.
4. Simultaneous requests: mem_wen and mem_ren asserted together → write completes first; the read issues only after DONE and mem_wen deasserted.
5. Error responses: bresp=2'b10 → mem_err pulses with mem_wvalid; rresp=2'b11 → mem_err pulses with mem_rvalid.
6. Reset mid-read: rst=1 while in RRESP → m_rready=0 and mem_rvalid=0 next cycle; a subsequent read behaves as in scenario 3.

Source files
------------

// File: rtl/mem_axi_pkg.sv
// ============================================================================
// Module   : mem_axi_pkg
// Purpose  : Shared types for the Mem-to-AXI-lite master bridge: FSM state
//            encoding, AXI response codes and the latched write request.
// Contents : state_t, RESP_* codes, mem_req_t, resp_is_err()
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_axi_pkg;

    // Widest address/data/strobe the request struct can carry. The bridge
    // zero-extends narrower requests into it and truncates on the way out.
    localparam int MEM_ADDR_MAX = 64;
    localparam int MEM_DATA_MAX = 64;
    localparam int MEM_STRB_MAX = MEM_DATA_MAX / 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WREQ  = 3'd1,
        WRESP = 3'd2,
        RREQ  = 3'd3,
        RRESP = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [MEM_ADDR_MAX-1:0] addr;
        logic [MEM_DATA_MAX-1:0] data;
        logic [MEM_STRB_MAX-1:0] mask;
    } mem_req_t;

    // Anything other than OKAY (including EXOKAY) is reported to the core.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_axi_master.sv
// ============================================================================
// Module   : mem_axi_master
// Purpose  : Bridges single-beat Mem read/write requests to AXI-lite master
//            transactions, one outstanding transaction at a time.
// Ports    : clk, rst                    - clock, sync active-high reset
//            mem_wen/waddr/wdata/wmask   - write request (level, held)
//            mem_wvalid                  - write-complete pulse
//            mem_ren/raddr               - read request (level, held)
//            mem_rdata, mem_rvalid       - read data (held) and pulse
//            mem_err                     - error pulse with a completion
//            m_aw*, m_w*, m_b*           - AXI-lite write channels
//            m_ar*, m_r*                 - AXI-lite read channels
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_axi_master
    import mem_axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,   // at most MEM_ADDR_MAX
    parameter int DATA_WIDTH = 64    // multiple of 8, at most MEM_DATA_MAX
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_wen,
    input  logic [ADDR_WIDTH-1:0]   mem_waddr,
    input  logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH/8-1:0] mem_wmask,
    output logic                    mem_wvalid,
    input  logic                    mem_ren,
    input  logic [ADDR_WIDTH-1:0]   mem_raddr,
    output logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    mem_rvalid,
    output logic                    mem_err,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rvalid,
    output logic                    m_rready
);

    state_t                  state_q, state_d;
    mem_req_t                wreq_q, wreq_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic                    served_write_q, served_write_d;
    logic                    wpulse_q, wpulse_d;
    logic                    rpulse_q, rpulse_d;
    logic                    err_q, err_d;

    // A channel counts as done if it already finished or finishes this cycle.
    logic aw_fire, w_fire, aw_ok, w_ok;
    assign aw_fire = awvalid_q & m_awready;
    assign w_fire  = wvalid_q & m_wready;
    assign aw_ok   = aw_done_q | aw_fire;
    assign w_ok    = w_done_q | w_fire;

    always_comb begin
        state_d        = state_q;
        wreq_d         = wreq_q;
        araddr_d       = araddr_q;
        rdata_d        = rdata_q;
        awvalid_d      = awvalid_q;
        wvalid_d       = wvalid_q;
        bready_d       = bready_q;
        arvalid_d      = arvalid_q;
        rready_d       = rready_q;
        aw_done_d      = aw_done_q;
        w_done_d       = w_done_q;
        served_write_d = served_write_q;
        wpulse_d       = 1'b0;
        rpulse_d       = 1'b0;
        err_d          = 1'b0;

        case (state_q)
            IDLE: begin
                // Write has priority; a concurrent read waits for DONE.
                if (mem_wen) begin
                    wreq_d = '{addr: MEM_ADDR_MAX'(mem_waddr),
                               data: MEM_DATA_MAX'(mem_wdata),
                               mask: MEM_STRB_MAX'(mem_wmask)};
                    awvalid_d      = 1'b1;
                    wvalid_d       = 1'b1;
                    aw_done_d      = 1'b0;
                    w_done_d       = 1'b0;
                    served_write_d = 1'b1;
                    state_d        = WREQ;
                end else if (mem_ren) begin
                    araddr_d       = mem_raddr;
                    arvalid_d      = 1'b1;
                    served_write_d = 1'b0;
                    state_d        = RREQ;
                end
            end
            WREQ: begin
                if (aw_fire) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_fire) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_ok && w_ok) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    bready_d  = 1'b1;
                    state_d   = WRESP;
                end
            end
            WRESP: begin
                if (m_bvalid) begin
                    bready_d = 1'b0;
                    wpulse_d = 1'b1;
                    err_d    = resp_is_err(m_bresp);
                    state_d  = DONE;
                end
            end
            RREQ: begin
                if (m_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RRESP;
                end
            end
            RRESP: begin
                if (m_rvalid) begin
                    rready_d = 1'b0;
                    rdata_d  = m_rdata;
                    rpulse_d = 1'b1;
                    err_d    = resp_is_err(m_rresp);
                    state_d  = DONE;
                end
            end
            DONE: begin
                // Wait for the serviced level to drop so it is not reissued.
                if (served_write_q ? !mem_wen : !mem_ren) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            wreq_q         <= '0;
            araddr_q       <= '0;
            rdata_q        <= '0;
            awvalid_q      <= 1'b0;
            wvalid_q       <= 1'b0;
            bready_q       <= 1'b0;
            arvalid_q      <= 1'b0;
            rready_q       <= 1'b0;
            aw_done_q      <= 1'b0;
            w_done_q       <= 1'b0;
            served_write_q <= 1'b0;
            wpulse_q       <= 1'b0;
            rpulse_q       <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            wreq_q         <= wreq_d;
            araddr_q       <= araddr_d;
            rdata_q        <= rdata_d;
            awvalid_q      <= awvalid_d;
            wvalid_q       <= wvalid_d;
            bready_q       <= bready_d;
            arvalid_q      <= arvalid_d;
            rready_q       <= rready_d;
            aw_done_q      <= aw_done_d;
            w_done_q       <= w_done_d;
            served_write_q <= served_write_d;
            wpulse_q       <= wpulse_d;
            rpulse_q       <= rpulse_d;
            err_q          <= err_d;
        end
    end

    assign m_awaddr   = wreq_q.addr[ADDR_WIDTH-1:0];
    assign m_wdata    = wreq_q.data[DATA_WIDTH-1:0];
    assign m_wstrb    = wreq_q.mask[DATA_WIDTH/8-1:0];
    assign m_awvalid  = awvalid_q;
    assign m_wvalid   = wvalid_q;
    assign m_bready   = bready_q;
    assign m_araddr   = araddr_q;
    assign m_arvalid  = arvalid_q;
    assign m_rready   = rready_q;
    assign mem_rdata  = rdata_q;
    assign mem_wvalid = wpulse_q;
    assign mem_rvalid = rpulse_q;
    assign mem_err    = err_q;

endmodule

`default_nettype wire
